// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way intersection controller (NS / EW).
// Sequences light phases on the 1 Hz tick, counts down the remaining seconds
// of each phase and drives BCD digits for a 7-segment countdown display.
// A pedestrian request shortens the current (or next) green phase.
// Optional night flashing mode: define TRAFFIC_NIGHT_FLASH_EN to add the
// night input and the FLASH state.
module traffic_light_ctrl #(
    parameter int GREEN_NS_S  = 30,
    parameter int GREEN_EW_S  = 20,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 2,
    parameter int MIN_GREEN_S = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [5:0] remain,
    output logic [3:0] remain_tens,
    output logic [3:0] remain_ones
);

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_RED1  = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_RED2  = 3'd5
`ifdef TRAFFIC_NIGHT_FLASH_EN
        ,
        S_FLASH = 3'd6
`endif
    } state_t;

    // Binary (0..63) to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rest;
        tens = 4'd0;
        rest = v;
        for (int k = 0; k < 6; k++) begin
            if (rest >= 6'd10) begin
                rest = rest - 6'd10;
                tens = tens + 4'd1;
            end else begin
                rest = rest;
            end
        end
        return {tens, 4'(rest)};
    endfunction

    // Light pattern {ns, ew} for a timed state; anything unknown shows all red.
    function automatic logic [5:0] decode_lights(input state_t s);
        logic [5:0] lights;
        case (s)
            S_NS_G:  lights = 6'b001_100;
            S_NS_Y:  lights = 6'b010_100;
            S_RED1:  lights = 6'b100_100;
            S_EW_G:  lights = 6'b100_001;
            S_EW_Y:  lights = 6'b100_010;
            S_RED2:  lights = 6'b100_100;
            default: lights = 6'b100_100;
        endcase
        return lights;
    endfunction

    localparam logic [5:0] L_GNS      = 6'(GREEN_NS_S);
    localparam logic [5:0] L_GNS_M1   = 6'(GREEN_NS_S - 1);
    localparam logic [5:0] L_GEW_M1   = 6'(GREEN_EW_S - 1);
    localparam logic [5:0] L_YEL_M1   = 6'(YELLOW_S - 1);
    localparam logic [5:0] L_ALLRED_M1 = 6'(ALLRED_S - 1);
    localparam logic [5:0] L_MIN_M1   = 6'(MIN_GREEN_S - 1);
    localparam logic [7:0] L_RST_BCD  = bin_to_bcd(L_GNS);

    state_t     r_state;
    logic [5:0] r_cnt;
    logic       r_ped_pend;

    state_t     w_seq_state;
    logic [5:0] w_seq_cnt;
    state_t     w_next_state;
    logic [5:0] w_next_cnt;
    logic       w_ped_clear;
    logic       w_next_ped;
    logic [5:0] w_lights;
    logic [5:0] w_next_remain;
    logic [7:0] w_bcd;

`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic       r_flash_on;
    logic       w_next_flash_on;
`endif

    // Normal phase sequencing as it would happen on a tick: advance at zero,
    // clamp to the minimum green for a pending pedestrian, else count down.
    always_comb begin
        w_seq_state = r_state;
        w_seq_cnt   = r_cnt;
        if (r_cnt == 6'd0) begin
            case (r_state)
                S_NS_G:  begin w_seq_state = S_NS_Y; w_seq_cnt = L_YEL_M1;    end
                S_NS_Y:  begin w_seq_state = S_RED1; w_seq_cnt = L_ALLRED_M1; end
                S_RED1:  begin w_seq_state = S_EW_G; w_seq_cnt = L_GEW_M1;    end
                S_EW_G:  begin w_seq_state = S_EW_Y; w_seq_cnt = L_YEL_M1;    end
                S_EW_Y:  begin w_seq_state = S_RED2; w_seq_cnt = L_ALLRED_M1; end
                S_RED2:  begin w_seq_state = S_NS_G; w_seq_cnt = L_GNS_M1;    end
                default: begin w_seq_state = S_NS_G; w_seq_cnt = L_GNS_M1;    end
            endcase
        end else if (((r_state == S_NS_G) || (r_state == S_EW_G)) &&
                     r_ped_pend && (r_cnt > L_MIN_M1)) begin
            w_seq_cnt = L_MIN_M1;
        end else begin
            w_seq_cnt = r_cnt - 6'd1;
        end
    end

    // Select the next state/count: nothing moves without a tick; night mode
    // (when built in) overrides the normal sequence.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        w_next_flash_on = r_flash_on;
`endif
        if (tick) begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
            if (night) begin
                w_next_state    = S_FLASH;
                w_next_flash_on = (r_state == S_FLASH) ? ~r_flash_on : 1'b1;
            end else if (r_state == S_FLASH) begin
                w_next_state    = S_RED2;
                w_next_cnt      = L_ALLRED_M1;
                w_next_flash_on = 1'b0;
            end else begin
                w_next_state = w_seq_state;
                w_next_cnt   = w_seq_cnt;
            end
`else
            w_next_state = w_seq_state;
            w_next_cnt   = w_seq_cnt;
`endif
        end else begin
            w_next_state = r_state;
            w_next_cnt   = r_cnt;
        end
    end

    // Pedestrian request is sticky until a yellow is entered; a request in
    // the clearing cycle keeps it pending.
    always_comb begin
        w_ped_clear = tick && (w_next_state != r_state) &&
                      ((w_next_state == S_NS_Y) || (w_next_state == S_EW_Y));
        w_next_ped  = ped_req | (r_ped_pend & ~w_ped_clear);
    end

    // Output values derived from the next state so they register alongside it.
    always_comb begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if (w_next_state == S_FLASH) begin
            w_lights      = w_next_flash_on ? 6'b010_010 : 6'b000_000;
            w_next_remain = 6'd0;
        end else begin
            w_lights      = decode_lights(w_next_state);
            w_next_remain = w_next_cnt + 6'd1;
        end
`else
        w_lights      = decode_lights(w_next_state);
        w_next_remain = w_next_cnt + 6'd1;
`endif
        w_bcd = bin_to_bcd(w_next_remain);
    end

    // State, counter, pedestrian flag and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_NS_G;
            r_cnt       <= L_GNS_M1;
            r_ped_pend  <= 1'b0;
            ns_light    <= 3'b001;
            ew_light    <= 3'b100;
            remain      <= L_GNS;
            remain_tens <= L_RST_BCD[7:4];
            remain_ones <= L_RST_BCD[3:0];
`ifdef TRAFFIC_NIGHT_FLASH_EN
            r_flash_on  <= 1'b0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_ped_pend  <= w_next_ped;
            ns_light    <= w_lights[5:3];
            ew_light    <= w_lights[2:0];
            remain      <= w_next_remain;
            remain_tens <= w_bcd[7:4];
            remain_ones <= w_bcd[3:0];
`ifdef TRAFFIC_NIGHT_FLASH_EN
            r_flash_on  <= w_next_flash_on;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: a table of full-cycle tick
// vectors plus hand-written sequences for hold, pedestrian, reset and night.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ped_req;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic       night;
`endif
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [5:0] remain;
    logic [3:0] remain_tens;
    logic [3:0] remain_ones;

    traffic_light_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ped_req     (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        .night       (night),
`endif
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .remain      (remain),
        .remain_tens (remain_tens),
        .remain_ones (remain_ones)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] remain;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       flash;
    } exp_t;

    typedef struct packed {
        logic       tick;
        logic       ped;
        logic [5:0] remain;
        logic [2:0] ns;
        logic [2:0] ew;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int         dur   [6] = '{30, 3, 2, 20, 3, 2};
    logic [2:0] ns_of [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_of [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int m_ph;
    int m_rem;

    function automatic exp_t mk(input logic [5:0] r, input logic [2:0] ns,
                                input logic [2:0] ew, input logic fl);
        exp_t e;
        e.remain = r;
        e.ns     = ns;
        e.ew     = ew;
        e.tens   = 4'(r / 6'd10);
        e.ones   = 4'(r % 6'd10);
        e.flash  = fl;
        return e;
    endfunction

    function automatic exp_t m_exp();
        return mk(6'(m_rem), ns_of[m_ph], ew_of[m_ph], 1'b0);
    endfunction

    task automatic m_step();
        if (m_rem == 1) begin
            m_ph  = (m_ph + 1) % 6;
            m_rem = dur[m_ph];
        end else begin
            m_rem = m_rem - 1;
        end
    endtask

    task automatic check(input string nm);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry in scoreboard", nm);
        end else begin
            e = sb_q.pop_front();
            if (remain !== e.remain || ns_light !== e.ns || ew_light !== e.ew ||
                remain_tens !== e.tens || remain_ones !== e.ones) begin
                n_bad++;
                $display("FAIL %s: got remain=%0d ns=%b ew=%b bcd=%0d/%0d, want remain=%0d ns=%b ew=%b bcd=%0d/%0d",
                         nm, remain, ns_light, ew_light, remain_tens, remain_ones,
                         e.remain, e.ns, e.ew, e.tens, e.ones);
            end
            if (!e.flash) begin
                n_cmp++;
                if (!$onehot(ns_light) || !$onehot(ew_light) ||
                    (ns_light != 3'b100 && ew_light != 3'b100)) begin
                    n_bad++;
                    $display("FAIL %s_safety: ns=%b ew=%b, want one-hot with at least one red",
                             nm, ns_light, ew_light);
                end
            end
        end
    endtask

    // One tick pulse, then three idle clocks; check on a falling edge.
    task automatic do_tick(input exp_t e, input string nm);
        @(negedge clk);
        tick = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        tick = 1'b0;
        check(nm);
        repeat (2) @(negedge clk);
    endtask

    task automatic tick_model(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            m_step();
            do_tick(m_exp(), nm);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick = 1'b0;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_ph  = 0;
        m_rem = 30;
        sb_q.push_back(m_exp());
        check("reset");
    endtask

    task automatic pulse_ped();
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vt [60];
        int   ph;
        int   rem;

        // Full cycle table: every tick from reset through one complete cycle.
        ph  = 0;
        rem = 30;
        for (int i = 0; i < 60; i++) begin
            if (rem == 1) begin
                ph  = (ph + 1) % 6;
                rem = dur[ph];
            end else begin
                rem = rem - 1;
            end
            vt[i].tick   = 1'b1;
            vt[i].ped    = 1'b0;
            vt[i].remain = 6'(rem);
            vt[i].ns     = ns_of[ph];
            vt[i].ew     = ew_of[ph];
        end

        rst     = 1'b1;
        tick    = 1'b0;
        ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        night   = 1'b0;
`endif
        do_reset();

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            tick    = vt[i].tick;
            ped_req = vt[i].ped;
            sb_q.push_back(mk(vt[i].remain, vt[i].ns, vt[i].ew, 1'b0));
            @(negedge clk);
            tick    = 1'b0;
            ped_req = 1'b0;
            check("cycle");
            repeat (2) @(negedge clk);
        end

        // Outputs hold with tick low.
        do_reset();
        tick_model(13, "to_17");
        for (int k = 0; k < 10; k++) begin
            repeat (100) @(negedge clk);
            sb_q.push_back(mk(6'd17, 3'b001, 3'b100, 1'b0));
            check("hold17");
        end

        // Pedestrian shortening of NS green and clearing on NS yellow.
        do_reset();
        tick_model(5, "to_25");
        pulse_ped();
        m_rem = 5;
        do_tick(m_exp(), "ped_short");
        tick_model(5, "ped_to_nsy");
        tick_model(6, "ped_cleared");
        tick_model(16, "to_ew3");
        pulse_ped();
        tick_model(3, "ew_no_short");
        tick_model(3, "to_red2");
        pulse_ped();
        tick_model(2, "red2_to_nsg");
        m_rem = 5;
        do_tick(m_exp(), "red2_ped_short");

        // Asynchronous reset in the middle of EW yellow.
        tick_model(31, "to_ewy2");
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_ph  = 0;
        m_rem = 30;
        sb_q.push_back(m_exp());
        check("async_rst");
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(m_exp());
        check("after_rst");
        tick_model(1, "after_rst_tick");

`ifdef TRAFFIC_NIGHT_FLASH_EN
        // Night flashing and recovery through all-red.
        do_reset();
        night = 1'b1;
        do_tick(mk(6'd0, 3'b010, 3'b010, 1'b1), "flash_on1");
        do_tick(mk(6'd0, 3'b000, 3'b000, 1'b1), "flash_off");
        do_tick(mk(6'd0, 3'b010, 3'b010, 1'b1), "flash_on2");
        night = 1'b0;
        m_ph  = 5;
        m_rem = 2;
        do_tick(m_exp(), "flash_to_red2");
        tick_model(2, "flash_recover");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
